// File: rtl/man_move_ctrl.sv
// Player move sequencer for the 8x8 Sokoban board: checks walls/boxes in the map RAM,
// performs box pushes and commits the sprite position/direction only around vertical blanking.
module man_move_ctrl #(
  parameter logic [5:0] START_POS = 6'd9,
  parameter logic [1:0] START_DIR = 2'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       move_req,
  input  logic [1:0] move_dir,
  input  logic       vblank,
  input  logic       level_load,
  input  logic [5:0] load_pos,
  output logic       move_ack,
  output logic       busy,
  output logic [5:0] map_addr,
  output logic       map_rd_en,
  input  logic [2:0] map_rd_data,
  output logic       map_wr_en,
  output logic [2:0] map_wr_data,
  output logic [5:0] man,
  output logic [1:0] direction,
  output logic [9:0] step_cnt,
  output logic [9:0] push_cnt
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_RD1     = 4'd1,
    S_CHK1    = 4'd2,
    S_RD2     = 4'd3,
    S_CHK2    = 4'd4,
    S_WAIT_VB = 4'd5,
    S_WR1     = 4'd6,
    S_WR2     = 4'd7,
    S_COMMIT  = 4'd8
  } state_t;

  state_t     state_r, state_nxt_s;
  logic [1:0] dir_r;
  logic [5:0] next_r, beyond_r;
  logic       beyond_off_r, blocked_r, push_r;
  logic [2:0] tile_next_r, tile_beyond_r;
  logic [5:0] man_r;
  logic [1:0] direction_r;
  logic [9:0] step_cnt_r, push_cnt_r;
  logic [6:0] next_s, beyond_s;

  // Returns {off_grid, cell} for one step from pos; no wrap-around at the board edge.
  function automatic logic [6:0] step_cell(input logic [5:0] pos, input logic [1:0] dir);
    logic [2:0] row, col;
    logic       off;
    logic [5:0] res;
    row = pos[5:3];
    col = pos[2:0];
    off = 1'b0;
    res = pos;
    case (dir)
      2'd0: if (row == 3'd0) off = 1'b1; else res = {row - 3'd1, col};
      2'd1: if (row == 3'd7) off = 1'b1; else res = {row + 3'd1, col};
      2'd2: if (col == 3'd0) off = 1'b1; else res = {row, col - 3'd1};
      2'd3: if (col == 3'd7) off = 1'b1; else res = {row, col + 3'd1};
      default: off = 1'b1;
    endcase
    return {off, res};
  endfunction

  assign next_s   = step_cell(man_r, move_dir);
  assign beyond_s = step_cell(next_s[5:0], move_dir);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state decode; a level load aborts whatever is in flight
  always_comb begin
    state_nxt_s = state_r;
    if (level_load) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:    if (move_req) state_nxt_s = next_s[6] ? S_WAIT_VB : S_RD1;
                   else          state_nxt_s = S_IDLE;
        S_RD1:     state_nxt_s = S_CHK1;
        S_CHK1:    if (map_rd_data[0])      state_nxt_s = S_WAIT_VB;
                   else if (map_rd_data[1]) state_nxt_s = beyond_off_r ? S_WAIT_VB : S_RD2;
                   else                     state_nxt_s = S_WAIT_VB;
        S_RD2:     state_nxt_s = S_CHK2;
        S_CHK2:    state_nxt_s = S_WAIT_VB;
        S_WAIT_VB: if (vblank) state_nxt_s = push_r ? S_WR1 : S_COMMIT;
                   else        state_nxt_s = S_WAIT_VB;
        S_WR1:     state_nxt_s = S_WR2;
        S_WR2:     state_nxt_s = S_COMMIT;
        S_COMMIT:  state_nxt_s = S_IDLE;
        default:   state_nxt_s = S_IDLE;
      endcase
    end
  end

  // Move context, tile captures, sprite registers and saturating counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_r <= 2'd0; next_r <= 6'd0; beyond_r <= 6'd0; beyond_off_r <= 1'b0;
      blocked_r <= 1'b0; push_r <= 1'b0; tile_next_r <= 3'd0; tile_beyond_r <= 3'd0;
      man_r <= START_POS; direction_r <= START_DIR; step_cnt_r <= 10'd0; push_cnt_r <= 10'd0;
    end else if (level_load) begin
      blocked_r <= 1'b0; push_r <= 1'b0;
      man_r <= load_pos; direction_r <= START_DIR; step_cnt_r <= 10'd0; push_cnt_r <= 10'd0;
    end else begin
      case (state_r)
        S_IDLE: if (move_req) begin
          dir_r        <= move_dir;
          next_r       <= next_s[5:0];
          beyond_r     <= beyond_s[5:0];
          beyond_off_r <= beyond_s[6];
          blocked_r    <= next_s[6];
          push_r       <= 1'b0;
        end
        S_CHK1: begin
          tile_next_r <= map_rd_data;
          if (map_rd_data[0] || (map_rd_data[1] && beyond_off_r)) blocked_r <= 1'b1;
        end
        S_CHK2: begin
          tile_beyond_r <= map_rd_data;
          if (map_rd_data[1:0] != 2'b00) blocked_r <= 1'b1;
          else                           push_r    <= 1'b1;
        end
        S_COMMIT: begin
          direction_r <= dir_r;
          if (!blocked_r) begin
            man_r <= next_r;
            if (step_cnt_r != 10'd1023) step_cnt_r <= step_cnt_r + 10'd1;
          end
          if (push_r && (push_cnt_r != 10'd1023)) push_cnt_r <= push_cnt_r + 10'd1;
        end
        default: ;
      endcase
    end
  end

  // Map strobes, busy and ack decoded from the current state; a same-cycle load kills writes/ack
  always_comb begin
    map_rd_en   = 1'b0;
    map_wr_en   = 1'b0;
    map_addr    = 6'd0;
    map_wr_data = 3'd0;
    move_ack    = 1'b0;
    busy        = (state_r != S_IDLE);
    case (state_r)
      S_RD1:    begin map_rd_en = 1'b1; map_addr = next_r; end
      S_RD2:    begin map_rd_en = 1'b1; map_addr = beyond_r; end
      S_WR1:    begin map_wr_en = ~level_load; map_addr = next_r;   map_wr_data = tile_next_r & 3'b101; end
      S_WR2:    begin map_wr_en = ~level_load; map_addr = beyond_r; map_wr_data = tile_beyond_r | 3'b010; end
      S_COMMIT: move_ack = ~level_load;
      default:  ;
    endcase
  end

  assign man       = man_r;
  assign direction = direction_r;
  assign step_cnt  = step_cnt_r;
  assign push_cnt  = push_cnt_r;

endmodule
